// File: rtl/mvm_sequencer_pkg.sv
// Shared constants for the matrix-vector sequencer: register word indices,
// CTRL/STATUS bit positions, FSM state encoding and a byte-lane merge helper.
package mvm_sequencer_pkg;

  // Word indices (byte address bits [7:2])
  localparam logic [5:0] IDX_CTRL   = 6'd0;   // 0x00
  localparam logic [5:0] IDX_STATUS = 6'd1;   // 0x04
  localparam logic [5:0] IDX_MAT    = 6'd4;   // 0x10 + 4k
  localparam logic [5:0] IDX_VEC    = 6'd16;  // 0x40 + 4k
  localparam logic [5:0] IDX_RES    = 6'd24;  // 0x60 + 4k

  // CTRL bits
  localparam int CTRL_START = 0;
  localparam int CTRL_CLR   = 1;
  localparam int CTRL_IE    = 2;

  // STATUS bits
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_CAPT = 2'd2
  } state_e;

  // Replace only the byte lanes selected by sel.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = sel[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mvm_sequencer_if.sv
// Wishbone slave bus bundle between the host and the matrix-vector sequencer.
interface mvm_sequencer_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/mvm_sequencer_wb_regfile.sv
// Wishbone register file: address decode, byte-masked operand/CTRL writes,
// registered read mux and single-cycle ack. Operand writes are refused while
// the sequencer is busy and reported through drop_o.
module mvm_sequencer_wb_regfile
  import mvm_sequencer_pkg::*;
#(
  parameter int MAT_W    = 4,
  parameter int VEC_W    = 1,
  parameter int RES_W    = 1,
  parameter int MAT_BITS = 128,
  parameter int VEC_BITS = 32,
  parameter int RES_BITS = 32
) (
  input  logic                clk,
  input  logic                rstn,
  mvm_sequencer_if.slave      wb,
  input  logic                busy_i,
  input  logic                done_i,
  input  logic                err_i,
  input  logic [RES_BITS-1:0] result_i,
  output logic [MAT_BITS-1:0] mat_o,
  output logic [VEC_BITS-1:0] vec_o,
  output logic                ie_nxt_o,
  output logic                start_o,
  output logic                clr_o,
  output logic                drop_o
);

  localparam int MAT_PAD = MAT_W * 32;
  localparam int VEC_PAD = VEC_W * 32;
  localparam int RES_PAD = RES_W * 32;
  // Operand bits beyond the core width are forced to zero so they read back 0.
  localparam logic [MAT_PAD-1:0] MAT_ONE  = {{(MAT_PAD-1){1'b0}}, 1'b1};
  localparam logic [VEC_PAD-1:0] VEC_ONE  = {{(VEC_PAD-1){1'b0}}, 1'b1};
  localparam logic [MAT_PAD-1:0] MAT_MASK = (MAT_ONE << MAT_BITS) - MAT_ONE;
  localparam logic [VEC_PAD-1:0] VEC_MASK = (VEC_ONE << VEC_BITS) - VEC_ONE;

  logic [MAT_PAD-1:0] mat_q, mat_d;
  logic [VEC_PAD-1:0] vec_q, vec_d;
  logic               ie_q, ie_d;
  logic               ack_q, ack_d;
  logic [31:0]        dat_q, dat_d;

  logic               req_s, wr_s, rd_s, is_op_s;
  logic [5:0]         widx_s;
  logic [31:0]        rdata_s;
  logic [RES_PAD-1:0] res_pad_s;
  logic               unused_adr_s;

  assign req_s        = wb.wbs_stb_i & wb.wbs_cyc_i & ~ack_q;
  assign wr_s         = req_s & wb.wbs_we_i;
  assign rd_s         = req_s & ~wb.wbs_we_i;
  assign widx_s       = wb.wbs_adr_i[7:2];
  assign res_pad_s    = RES_PAD'(result_i);
  assign unused_adr_s = ^{wb.wbs_adr_i[31:8], wb.wbs_adr_i[1:0]};

  // Flag addresses that hit a matrix or vector operand word.
  always_comb begin
    is_op_s = 1'b0;
    for (int k = 0; k < MAT_W; k++) is_op_s = is_op_s | (widx_s == IDX_MAT + 6'(k));
    for (int k = 0; k < VEC_W; k++) is_op_s = is_op_s | (widx_s == IDX_VEC + 6'(k));
  end

  // Write decode: CTRL commands, byte-masked operand updates, busy-time drops.
  always_comb begin
    mat_d   = mat_q;
    vec_d   = vec_q;
    ie_d    = ie_q;
    start_o = 1'b0;
    clr_o   = 1'b0;
    drop_o  = 1'b0;
    if (wr_s) begin
      if (widx_s == IDX_CTRL) begin
        if (wb.wbs_sel_i[0]) begin
          start_o = wb.wbs_dat_i[CTRL_START];
          clr_o   = wb.wbs_dat_i[CTRL_CLR];
          ie_d    = wb.wbs_dat_i[CTRL_IE];
        end else begin
          ie_d = ie_q;
        end
      end else if (busy_i && is_op_s) begin
        drop_o = 1'b1;
      end else begin
        for (int k = 0; k < MAT_W; k++) begin
          mat_d[32*k +: 32] = (widx_s == IDX_MAT + 6'(k)) ?
            byte_merge(mat_q[32*k +: 32], wb.wbs_dat_i, wb.wbs_sel_i) : mat_d[32*k +: 32];
        end
        for (int k = 0; k < VEC_W; k++) begin
          vec_d[32*k +: 32] = (widx_s == IDX_VEC + 6'(k)) ?
            byte_merge(vec_q[32*k +: 32], wb.wbs_dat_i, wb.wbs_sel_i) : vec_d[32*k +: 32];
        end
      end
    end else begin
      drop_o = 1'b0;
    end
    mat_d = mat_d & MAT_MASK;
    vec_d = vec_d & VEC_MASK;
  end

  // Read mux; unmapped words return zero.
  always_comb begin
    rdata_s = 32'h0;
    case (widx_s)
      IDX_CTRL:   rdata_s[CTRL_IE] = ie_q;
      IDX_STATUS: begin
        rdata_s[STAT_BUSY] = busy_i;
        rdata_s[STAT_DONE] = done_i;
        rdata_s[STAT_ERR]  = err_i;
      end
      default: begin
        for (int k = 0; k < MAT_W; k++)
          rdata_s = (widx_s == IDX_MAT + 6'(k)) ? mat_q[32*k +: 32] : rdata_s;
        for (int k = 0; k < VEC_W; k++)
          rdata_s = (widx_s == IDX_VEC + 6'(k)) ? vec_q[32*k +: 32] : rdata_s;
        for (int k = 0; k < RES_W; k++)
          rdata_s = (widx_s == IDX_RES + 6'(k)) ? res_pad_s[32*k +: 32] : rdata_s;
      end
    endcase
    ack_d = req_s;
    dat_d = rd_s ? rdata_s : 32'h0;
  end

  // Register file, ack and read-data flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mat_q <= '0;
      vec_q <= '0;
      ie_q  <= 1'b0;
      ack_q <= 1'b0;
      dat_q <= 32'h0;
    end else begin
      mat_q <= mat_d;
      vec_q <= vec_d;
      ie_q  <= ie_d;
      ack_q <= ack_d;
      dat_q <= dat_d;
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;
  assign mat_o        = mat_q[MAT_BITS-1:0];
  assign vec_o        = vec_q[VEC_BITS-1:0];
  assign ie_nxt_o     = ie_d;

endmodule

// File: rtl/mvm_sequencer.sv
// Matrix-vector core sequencer: stages operands over Wishbone, runs the core
// with cen held for CORE_LAT cycles on START, then captures y into RESULT.
module mvm_sequencer
  import mvm_sequencer_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int WIDTH    = 8,
  parameter int CORE_LAT = 3
) (
  input  logic                        clk,
  input  logic                        rstn,
  mvm_sequencer_if.slave              wb,
  output logic [ROWS*COLS*WIDTH-1:0]  x1,
  output logic [COLS*WIDTH-1:0]       x2,
  output logic                        cen,
  input  logic [ROWS*WIDTH-1:0]       y,
  output logic                        busy,
  output logic                        irq
);

  localparam int MAT_BITS = ROWS * COLS * WIDTH;
  localparam int VEC_BITS = COLS * WIDTH;
  localparam int RES_BITS = ROWS * WIDTH;
  localparam int MAT_W    = (MAT_BITS + 31) / 32;
  localparam int VEC_W    = (VEC_BITS + 31) / 32;
  localparam int RES_W    = (RES_BITS + 31) / 32;
  localparam int CNT_W    = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CORE_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [RES_BITS-1:0] result_q, result_d;
  logic                cen_q, cen_d;
  logic                busy_q, busy_d;
  logic                irq_q, irq_d;

  logic                start_s, clr_s, drop_s, ie_nxt_s;

  mvm_sequencer_wb_regfile #(
    .MAT_W    (MAT_W),
    .VEC_W    (VEC_W),
    .RES_W    (RES_W),
    .MAT_BITS (MAT_BITS),
    .VEC_BITS (VEC_BITS),
    .RES_BITS (RES_BITS)
  ) u_regfile (
    .clk      (clk),
    .rstn     (rstn),
    .wb       (wb),
    .busy_i   (busy_q),
    .done_i   (done_q),
    .err_i    (err_q),
    .result_i (result_q),
    .mat_o    (x1),
    .vec_o    (x2),
    .ie_nxt_o (ie_nxt_s),
    .start_o  (start_s),
    .clr_o    (clr_s),
    .drop_o   (drop_s)
  );

  // Next-state logic: run sequencing, sticky done/err, registered outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    err_d    = err_q;
    result_d = result_q;
    // clr while busy only clears err; done belongs to the run in flight.
    if (clr_s) begin
      err_d  = 1'b0;
      done_d = busy_q ? done_q : 1'b0;
    end else begin
      err_d = err_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d = ST_RUN;
          cnt_d   = CNT_LOAD;
          done_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = ST_CAPT;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_CAPT: begin
        result_d = y;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Refused starts and operand writes during a run flag an error.
    if (busy_q && (start_s || drop_s)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_d;
    end
    cen_d  = (state_d == ST_RUN);
    busy_d = (state_d != ST_IDLE);
    irq_d  = done_d & ie_nxt_s;
  end

  // Sequencer state and output flops; reset returns to IDLE with everything cleared.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_ZERO;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      cen_q    <= 1'b0;
      busy_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
      cen_q    <= cen_d;
      busy_q   <= busy_d;
      irq_q    <= irq_d;
    end
  end

  assign cen  = cen_q;
  assign busy = busy_q;
  assign irq  = irq_q;

endmodule

// File: tb/tb_mvm_sequencer.sv
// Self-checking bench for mvm_sequencer: a transaction-level model of the
// register map and run timing is compared against the DUT every cycle, and
// directed scenarios pin the model with hand-computed values.
module tb_mvm_sequencer;
  localparam int ROWS = 4, COLS = 4, WIDTH = 8, CORE_LAT = 3;

  logic         clk  = 1'b0;
  logic         rstn = 1'b0;
  logic [127:0] x1;
  logic [31:0]  x2;
  logic         cen;
  logic [31:0]  y = 32'h0;
  logic         busy, irq;

  int errors = 0;
  int checks = 0;
  int cen_cnt = 0, busy_cnt = 0, ack_b2b = 0;
  logic prev_ack = 1'b0;

  mvm_sequencer_if wb();

  mvm_sequencer #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH), .CORE_LAT(CORE_LAT)) dut (
    .clk(clk), .rstn(rstn), .wb(wb), .x1(x1), .x2(x2), .cen(cen), .y(y), .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  // Core stand-in: signed matrix-vector product, element-truncated, advances only with cen.
  function automatic logic [31:0] mv_product(input logic [127:0] m, input logic [31:0] v);
    logic [31:0] r;
    r = 32'h0;
    for (int ri = 0; ri < ROWS; ri++) begin
      int acc;
      acc = 0;
      for (int c = 0; c < COLS; c++)
        acc += int'($signed(m[(ri*COLS+c)*WIDTH +: WIDTH])) * int'($signed(v[c*WIDTH +: WIDTH]));
      r[ri*WIDTH +: WIDTH] = acc[7:0];
    end
    return r;
  endfunction

  always @(posedge clk) if (cen) y <= mv_product(x1, x2);

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] m_mat [4];
  logic [31:0] m_vec = 32'h0, m_res = 32'h0, m_dat = 32'h0;
  logic        m_ie = 1'b0, m_done = 1'b0, m_err = 1'b0, m_ack = 1'b0;
  logic        m_cen = 1'b0, m_busy = 1'b0, m_irq = 1'b0;
  int          m_run = 0;   // cycles since the accepted start, 0 = not running

  task automatic model_step();
    logic req, wr, rd, busy_now;
    logic [5:0] widx;
    logic [31:0] rv;
    if (!rstn) begin
      for (int k = 0; k < 4; k++) m_mat[k] = 32'h0;
      m_vec = 32'h0; m_res = 32'h0; m_dat = 32'h0; m_ie = 1'b0; m_done = 1'b0;
      m_err = 1'b0; m_ack = 1'b0; m_cen = 1'b0; m_busy = 1'b0; m_irq = 1'b0; m_run = 0;
      return;
    end
    req = wb.wbs_stb_i & wb.wbs_cyc_i & ~m_ack;
    wr = req & wb.wbs_we_i;
    rd = req & ~wb.wbs_we_i;
    widx = wb.wbs_adr_i[7:2];
    busy_now = (m_run > 0);
    rv = 32'h0;
    if (widx == 6'd0) rv[2] = m_ie;
    else if (widx == 6'd1) rv = {29'h0, m_err, m_done, busy_now};
    else if (widx >= 6'd4 && widx < 6'd8) rv = m_mat[int'(widx) - 4];
    else if (widx == 6'd16) rv = m_vec;
    else if (widx == 6'd24) rv = m_res;
    if (m_run == CORE_LAT + 1) begin
      m_res = y; m_done = 1'b1; m_run = 0;
    end else if (m_run > 0) begin
      m_run++;
    end
    if (wr) begin
      if (widx == 6'd0) begin
        if (wb.wbs_sel_i[0]) begin
          if (wb.wbs_dat_i[1]) begin m_err = 1'b0; if (!busy_now) m_done = 1'b0; end
          if (wb.wbs_dat_i[0]) begin
            if (busy_now) m_err = 1'b1;
            else begin m_run = 1; m_done = 1'b0; end
          end
          m_ie = wb.wbs_dat_i[2];
        end
      end else if ((widx >= 6'd4 && widx < 6'd8) || widx == 6'd16) begin
        if (busy_now) m_err = 1'b1;
        else if (widx == 6'd16) m_vec = bmerge(m_vec, wb.wbs_dat_i, wb.wbs_sel_i);
        else m_mat[int'(widx) - 4] = bmerge(m_mat[int'(widx) - 4], wb.wbs_dat_i, wb.wbs_sel_i);
      end
    end
    m_ack = req;
    m_dat = rd ? rv : 32'h0;
    m_cen = (m_run >= 1 && m_run <= CORE_LAT);
    m_busy = (m_run > 0);
    m_irq = m_done & m_ie;
  endtask

  // Per-cycle compare of every DUT output against the model.
  initial begin
    for (int k = 0; k < 4; k++) m_mat[k] = 32'h0;
    forever begin
      @(posedge clk);
      model_step();
      #1;
      if (cen) cen_cnt++;
      if (busy) busy_cnt++;
      if (wb.wbs_ack_o && prev_ack) ack_b2b++;
      prev_ack = wb.wbs_ack_o;
      check("cyc_ack", wb.wbs_ack_o, m_ack);
      check("cyc_dat_o", wb.wbs_dat_o, m_dat);
      check("cyc_cen", cen, m_cen);
      check("cyc_busy", busy, m_busy);
      check("cyc_irq", irq, m_irq);
      check("cyc_x1", x1, {m_mat[3], m_mat[2], m_mat[1], m_mat[0]});
      check("cyc_x2", x2, m_vec);
    end
  end

  // ---------------- bus tasks (start and end at a negedge) ----------------
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rd);
    int n;
    logic got;
    wb.wbs_stb_i = 1'b1; wb.wbs_cyc_i = 1'b1; wb.wbs_we_i = we;
    wb.wbs_adr_i = adr; wb.wbs_dat_i = dat; wb.wbs_sel_i = sel;
    got = 1'b0; n = 0; rd = 32'h0;
    while (!got && n < 8) begin
      @(posedge clk); #1; n++;
      if (wb.wbs_ack_o) begin got = 1'b1; rd = wb.wbs_dat_o; end
    end
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout adr=%h actual=no_ack required=ack", adr);
    end
    @(negedge clk);
    wb.wbs_stb_i = 1'b0; wb.wbs_cyc_i = 1'b0; wb.wbs_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] d;
    wb_xfer(1'b1, adr, dat, sel, d);
  endtask

  task automatic wb_read_chk(input string name, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] d;
    wb_xfer(1'b0, adr, 32'h0, 4'hF, d);
    check(name, d, exp);
  endtask

  task automatic load_identity();
    wb_write(32'h10, 32'h0000_0001, 4'hF);
    wb_write(32'h14, 32'h0000_0100, 4'hF);
    wb_write(32'h18, 32'h0001_0000, 4'hF);
    wb_write(32'h1C, 32'h0100_0000, 4'hF);
    wb_write(32'h40, 32'h0403_0201, 4'hF);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int first_irq;
    int acks;
    wb.wbs_stb_i = 1'b0; wb.wbs_cyc_i = 1'b0; wb.wbs_we_i = 1'b0;
    wb.wbs_sel_i = 4'h0; wb.wbs_adr_i = 32'h0; wb.wbs_dat_i = 32'h0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_cen", cen, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_irq", irq, 1'b0);
    wb_read_chk("rst_status", 32'h04, 32'h0);
    wb_read_chk("rst_ctrl", 32'h00, 32'h0);

    // 1: identity run
    load_identity();
    cen_cnt = 0; busy_cnt = 0;
    wb_write(32'h00, 32'h1, 4'hF);
    repeat (6) @(negedge clk);
    check("t1_cen_cycles", cen_cnt, 3);
    check("t1_busy_cycles", busy_cnt, 4);
    wb_read_chk("t1_result", 32'h60, 32'h0403_0201);
    wb_read_chk("t1_status", 32'h04, 32'h2);

    // 2: operand write and second start while busy
    wb_write(32'h00, 32'h1, 4'hF);
    wb_write(32'h40, 32'h1122_3344, 4'hF);
    wb_read_chk("t2_status_busy", 32'h04, 32'h5);
    wb_read_chk("t2_status_done", 32'h04, 32'h6);
    wb_write(32'h00, 32'h2, 4'hF);
    wb_write(32'h00, 32'h1, 4'hF);
    wb_write(32'h00, 32'h1, 4'hF);
    repeat (6) @(negedge clk);
    wb_read_chk("t2_status_err", 32'h04, 32'h6);
    wb_read_chk("t2_vec_kept", 32'h40, 32'h0403_0201);
    wb_write(32'h00, 32'h2, 4'hF);
    wb_read_chk("t2_status_clr", 32'h04, 32'h0);

    // 3: byte-masked matrix write
    wb_write(32'h10, 32'h0, 4'hF);
    wb_write(32'h10, 32'hAABB_CCDD, 4'b0101);
    wb_read_chk("t3_masked", 32'h10, 32'h00BB_00DD);
    wb_write(32'h10, 32'h1, 4'hF);

    // 4: reset in the second RUN cycle
    wb_write(32'h00, 32'h1, 4'hF);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("t4_cen_drop", cen, 1'b0);
    check("t4_busy_drop", busy, 1'b0);
    check("t4_ack_drop", wb.wbs_ack_o, 1'b0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    wb_read_chk("t4_mat0_zero", 32'h10, 32'h0);
    wb_read_chk("t4_vec_zero", 32'h40, 32'h0);
    wb_read_chk("t4_status_zero", 32'h04, 32'h0);
    load_identity();
    wb_write(32'h00, 32'h1, 4'hF);
    repeat (6) @(negedge clk);
    wb_read_chk("t4_result", 32'h60, 32'h0403_0201);

    // 5: interrupt
    wb_write(32'h00, 32'h6, 4'hF);
    wb_write(32'h00, 32'h5, 4'hF);
    first_irq = -1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (irq && first_irq < 0) first_irq = i;
    end
    @(negedge clk);
    check("t5_irq_rise_cycle", first_irq, 4);
    check("t5_irq_high", irq, 1'b1);
    wb_write(32'h00, 32'h6, 4'hF);
    check("t5_irq_cleared", irq, 1'b0);

    // 6: unmapped read and held strobe
    wb_read_chk("t6_unmapped", 32'h80, 32'h0);
    wb.wbs_stb_i = 1'b1; wb.wbs_cyc_i = 1'b1; wb.wbs_we_i = 1'b0;
    wb.wbs_adr_i = 32'h88; wb.wbs_sel_i = 4'hF;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (wb.wbs_ack_o) acks++;
    end
    @(negedge clk);
    wb.wbs_stb_i = 1'b0; wb.wbs_cyc_i = 1'b0;
    check("t6_held_acks", acks, 2);
    repeat (2) @(negedge clk);
    check("ack_never_back_to_back", ack_b2b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
